// File: rtl/fifo_sync_hs_if.sv
// Handshake bundle for fifo_sync_hs: write side (s_*) and first-word-fall-through read side (m_*).
// master = producer/consumer environment, slave = the FIFO.
interface fifo_sync_hs_if #(
   parameter int DATA_WIDE = 64
);
   logic                 s_valid;
   logic                 s_ready;
   logic [DATA_WIDE-1:0] s_data;
   logic                 m_valid;
   logic                 m_ready;
   logic [DATA_WIDE-1:0] m_data;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );
endinterface

// File: rtl/fifo_sync_hs.sv
// Synchronous FWFT FIFO, any depth >= 2, with fill level, almost-full/empty flags and flush.
// Define FIFO_SYNC_HS_OREG_EN to source m_data/m_valid from an output register (2-edge latency).
module fifo_sync_hs #(
   parameter int  DATA_WIDE  = 64,
   parameter int  FIFO_DEPT  = 16,
   parameter int  AFULL_THR  = 12,
   parameter int  AEMPTY_THR = 2,
   parameter      MODE       = "block",
   localparam int LVL_W      = $clog2(FIFO_DEPT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   fifo_sync_hs_if.slave    bus,
   output logic [LVL_W-1:0] level,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int               PTR_W    = (FIFO_DEPT > 1) ? $clog2(FIFO_DEPT) : 1;
   localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPT);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPT - 1);

   if (FIFO_DEPT < 2) begin : g_bad_depth
      $error("fifo_sync_hs: FIFO_DEPT=%0d must be >= 2", FIFO_DEPT);
   end
   if (AFULL_THR < 1 || AFULL_THR > FIFO_DEPT) begin : g_bad_afull
      $error("fifo_sync_hs: AFULL_THR=%0d outside 1..%0d", AFULL_THR, FIFO_DEPT);
   end
   if (AEMPTY_THR < 0 || AEMPTY_THR > FIFO_DEPT - 1) begin : g_bad_aempty
      $error("fifo_sync_hs: AEMPTY_THR=%0d outside 0..%0d", AEMPTY_THR, FIFO_DEPT - 1);
   end

   (* ram_style = MODE *) logic [DATA_WIDE-1:0] mem [FIFO_DEPT];

   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LVL_W-1:0]     level_q;
   logic [LVL_W-1:0]     level_nxt;
   logic                 s_ready_q;
   logic                 push;
   logic                 pop;
   logic                 rd_adv;
   logic                 m_valid_w;
   logic [DATA_WIDE-1:0] m_data_w;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      push      = bus.s_valid & s_ready_q;
      pop       = m_valid_w & bus.m_ready;
      level_nxt = level_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         s_ready_q <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         s_ready_q <= 1'b1;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (rd_adv) rd_ptr <= ptr_inc(rd_ptr);
         level_q   <= level_nxt;
         s_ready_q <= (level_nxt < DEPTH_L);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= bus.s_data;
   end

`ifdef FIFO_SYNC_HS_OREG_EN
   logic                 oreg_vld_q;
   logic [DATA_WIDE-1:0] oreg_q;
   logic                 load;

   // The array holds level minus the output-register word; refill when the register empties or is taken.
   always_comb begin
      load      = (level_q != LVL_W'(oreg_vld_q)) && (!oreg_vld_q || bus.m_ready);
      rd_adv    = load;
      m_valid_w = oreg_vld_q;
      m_data_w  = oreg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oreg_vld_q <= 1'b0;
         oreg_q     <= '0;
      end else if (flush) begin
         oreg_vld_q <= 1'b0;
      end else if (load) begin
         oreg_vld_q <= 1'b1;
         oreg_q     <= mem[rd_ptr];
      end else if (pop) begin
         oreg_vld_q <= 1'b0;
      end
   end
`else
   logic [DATA_WIDE-1:0] hold_q;

   // hold_q shadows the visible head so m_data keeps its last value (and resets to 0) once empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         hold_q <= '0;
      else if (m_valid_w) hold_q <= mem[rd_ptr];
   end

   always_comb begin
      rd_adv    = pop;
      m_valid_w = (level_q != '0);
      m_data_w  = m_valid_w ? mem[rd_ptr] : hold_q;
   end
`endif

   assign bus.s_ready  = s_ready_q;
   assign bus.m_valid  = m_valid_w;
   assign bus.m_data   = m_data_w;
   assign level        = level_q;
   assign almost_full  = (level_q >= LVL_W'(AFULL_THR));
   assign almost_empty = (level_q <= LVL_W'(AEMPTY_THR));

endmodule

// File: tb/tb_fifo_sync_hs.sv
// Self-checking bench for fifo_sync_hs: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_fifo_sync_hs;
   localparam int DW    = 16;
   localparam int DEPTH = 5;
   localparam int AF    = 4;
   localparam int AE    = 1;
   localparam int LW    = $clog2(DEPTH + 1);
`ifdef FIFO_SYNC_HS_OREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [LW-1:0] level;
   logic          almost_full;
   logic          almost_empty;

   fifo_sync_hs_if #(.DATA_WIDE(DW)) bus ();

   fifo_sync_hs #(
      .DATA_WIDE (DW),
      .FIFO_DEPT (DEPTH),
      .AFULL_THR (AF),
      .AEMPTY_THR(AE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .level       (level),
      .almost_full (almost_full),
      .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   // Reference: a queue of stored words, each tagged with the edge index at which it was accepted.
   typedef struct {
      logic [DW-1:0] d;
      int            e;
   } entry_t;

   entry_t q[$];
   int     n = 0;
   bit     exp_ready = 1'b0;
   bit     did_push;
   int     errors = 0;
   int     checks = 0;

   // Head is visible once it has been stored for LAT-1 further edges.
   function automatic bit exp_mvalid();
      if (q.size() == 0) return 1'b0;
      return (n >= q[0].e + LAT - 1);
   endfunction

   function automatic logic [LW-1:0] exp_level();
      return LW'(q.size());
   endfunction

   task automatic drive_edge(input bit sv, input logic [DW-1:0] sd, input bit mr, input bit fl);
      bit psh, pp;
      bus.s_valid = sv;
      bus.s_data  = sd;
      bus.m_ready = mr;
      flush       = fl;
      psh = sv && exp_ready;
      pp  = exp_mvalid() && mr;
      @(posedge clk);
      n++;
      if (fl) begin
         q.delete();
         exp_ready = 1'b1;
      end else begin
         if (pp) void'(q.pop_front());
         if (psh) q.push_back(entry_t'{d: sd, e: n});
         exp_ready = (q.size() < DEPTH);
      end
      did_push = psh && !fl;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0; flush = 1'b0;
      rst_n = 1'b0; q.delete(); exp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready cyc%0d: got %b want 0", i, bus.s_ready); end
      end
      checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
      checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
      rst_n = 1'b1;
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL release_s_ready_pre_edge: got %b want 0", bus.s_ready); end
      drive_edge(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b want 1", bus.s_ready); end
      checks++; if (level !== '0) begin errors++; $display("FAIL release_level: got %0d want 0", level); end
   endtask

   // Fill to capacity with the consumer stalled; word 6 must stay with the source.
   task automatic test_fill(output int next_word);
      int v = 1;
      for (int c = 0; c < 8; c++) begin
         drive_edge(1'b1, DW'(v), 1'b0, 1'b0);
         if (did_push) v++;
         checks++; if (level !== exp_level()) begin errors++; $display("FAIL fill_level c%0d: got %0d want %0d", c, level, exp_level()); end
         checks++; if (almost_full !== (q.size() >= AF)) begin errors++; $display("FAIL fill_almost_full c%0d: got %b want %b", c, almost_full, q.size() >= AF); end
         checks++; if (bus.s_ready !== exp_ready) begin errors++; $display("FAIL fill_s_ready c%0d: got %b want %b", c, bus.s_ready, exp_ready); end
      end
      checks++; if (level !== LW'(5)) begin errors++; $display("FAIL fill_full_level: got %0d want 5", level); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL fill_full_s_ready: got %b want 0", bus.s_ready); end
      checks++; if (v !== 6) begin errors++; $display("FAIL fill_word6_held: next word %0d want 6", v); end
      checks++; if (bus.m_data !== DW'(1)) begin errors++; $display("FAIL fill_head: got %h want 0001", bus.m_data); end
      next_word = v;
   endtask

   task automatic test_wrap(input int first_word);
      int v = first_word;
      int exp_out = 1;
      int guard = 0;
      while ((v <= 20 || q.size() != 0) && guard < 200) begin
         checks++; if (bus.m_valid !== exp_mvalid()) begin errors++; $display("FAIL wrap_m_valid g%0d: got %b want %b", guard, bus.m_valid, exp_mvalid()); end
         if (exp_mvalid()) begin
            checks++; if (bus.m_data !== DW'(exp_out)) begin errors++; $display("FAIL wrap_sequence: got %0d want %0d", bus.m_data, exp_out); end
            exp_out++;
         end
         drive_edge(v <= 20, DW'(v), 1'b1, 1'b0);
         if (did_push) v++;
         guard++;
      end
      checks++; if (exp_out !== 21) begin errors++; $display("FAIL wrap_count: got %0d words want 20", exp_out - 1); end
      checks++; if (level !== '0) begin errors++; $display("FAIL wrap_drained_level: got %0d want 0", level); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) drive_edge(1'b1, DW'($urandom_range(0, 16'h7FFF)), 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         checks++; if (bus.m_data !== q[0].d) begin errors++; $display("FAIL b2b_order c%0d: got %h want %h", c, bus.m_data, q[0].d); end
         drive_edge(1'b1, DW'($urandom_range(0, 16'h7FFF)), 1'b1, 1'b0);
         checks++; if (level !== LW'(3)) begin errors++; $display("FAIL b2b_level c%0d: got %0d want 3", c, level); end
         checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready c%0d: got %b want 1", c, bus.s_ready); end
      end
   endtask

   task automatic test_flush();
      drive_edge(1'b1, 16'hDEAD, 1'b0, 1'b1);
      checks++; if (level !== '0) begin errors++; $display("FAIL flush_level: got %0d want 0", level); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid: got %b want 0", bus.m_valid); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL flush_s_ready: got %b want 1", bus.s_ready); end
      drive_edge(1'b1, 16'h1111, 1'b0, 1'b0);
      for (int k = 1; k < LAT; k++) drive_edge(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL flush_refill_valid: got %b want 1", bus.m_valid); end
      checks++; if (bus.m_data !== 16'h1111) begin errors++; $display("FAIL flush_refill_data: got %h want 1111", bus.m_data); end
      drive_edge(1'b0, '0, 1'b1, 1'b0);
      checks++; if (level !== '0) begin errors++; $display("FAIL flush_drain_level: got %0d want 0", level); end
   endtask

   task automatic test_single();
      drive_edge(1'b1, 16'h00A5, 1'b0, 1'b0);
      for (int k = 1; k <= LAT; k++) begin
         checks++; if (bus.m_valid !== ((k == LAT) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL single_latency edge%0d: got %b want %b", k, bus.m_valid, k == LAT); end
         if (k < LAT) drive_edge(1'b0, '0, 1'b0, 1'b0);
      end
      for (int c = 0; c < 4; c++) begin
         drive_edge(1'b0, '0, 1'b0, 1'b0);
         checks++; if (bus.m_data !== 16'h00A5 || bus.m_valid !== 1'b1) begin errors++; $display("FAIL single_hold c%0d: got v=%b d=%h want v=1 d=00a5", c, bus.m_valid, bus.m_data); end
      end
      drive_edge(1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL single_popped_valid: got %b want 0", bus.m_valid); end
      checks++; if (bus.m_data !== 16'h00A5) begin errors++; $display("FAIL single_last_value: got %h want 00a5", bus.m_data); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL single_almost_empty: got %b want 1", almost_empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) drive_edge(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
      drive_edge(1'b0, '0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      q.delete(); exp_ready = 1'b0;
      #1;
      checks++; if (level !== '0) begin errors++; $display("FAIL async_level: got %0d want 0", level); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL async_s_ready: got %b want 0", bus.s_ready); end
      checks++; if (bus.m_valid !== 1'b0 || bus.m_data !== '0) begin errors++; $display("FAIL async_output: got v=%b d=%h want v=0 d=0", bus.m_valid, bus.m_data); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive_edge(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL async_release_s_ready: got %b want 1", bus.s_ready); end
   endtask

   task automatic test_random();
      int pv, pr;
      for (int c = 0; c < 400; c++) begin
         pv = (c < 200) ? 80 : 30;
         pr = (c < 200) ? 30 : 80;
         checks++; if (level !== exp_level()) begin errors++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, level, exp_level()); end
         checks++; if (bus.s_ready !== exp_ready) begin errors++; $display("FAIL rnd_s_ready c%0d: got %b want %b", c, bus.s_ready, exp_ready); end
         checks++; if (bus.m_valid !== exp_mvalid()) begin errors++; $display("FAIL rnd_m_valid c%0d: got %b want %b", c, bus.m_valid, exp_mvalid()); end
         if (exp_mvalid()) begin
            checks++; if (bus.m_data !== q[0].d) begin errors++; $display("FAIL rnd_m_data c%0d: got %h want %h", c, bus.m_data, q[0].d); end
         end
         checks++; if (almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE)) begin
            errors++; $display("FAIL rnd_flags c%0d: got af=%b ae=%b for level %0d", c, almost_full, almost_empty, q.size());
         end
         drive_edge($urandom_range(0, 99) < pv, DW'($urandom), $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 3);
      end
   endtask

   initial begin
      int nw;
      test_reset();
      test_fill(nw);
      test_wrap(nw);
      test_back_to_back();
      test_flush();
      test_single();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded 100000 ns");
      $fatal(1, "timeout");
   end
endmodule
